// File: rtl/loop_addr_gen_if.sv
// Address-beat channel of loop_addr_gen: valid/ready handshake plus the address and
// loop indices that travel with each beat.
interface loop_addr_gen_if #(
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 16
);
  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  idx_0;
  logic [CNT_W-1:0]  idx_1;
  logic [CNT_W-1:0]  idx_2;
  logic [CNT_W-1:0]  idx_3;
  logic              last;

  modport master (output addr_valid, addr, idx_0, idx_1, idx_2, idx_3, last,
                  input  addr_ready);
  modport slave  (input  addr_valid, addr, idx_0, idx_1, idx_2, idx_3, last,
                  output addr_ready);
endinterface

// File: rtl/loop_addr_gen.sv
// Four-level nested-loop address sequencer with incremental (multiplier-free) address accumulators.
// Optional feature macro: LOOP_GEN_STALL_CNT_EN adds a saturating backpressure cycle counter.
module loop_addr_gen #(
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [CNT_W-1:0]  max_0_i,
  input  logic [CNT_W-1:0]  max_1_i,
  input  logic [CNT_W-1:0]  max_2_i,
  input  logic [CNT_W-1:0]  max_3_i,
  input  logic [ADDR_W-1:0] stride_0_i,
  input  logic [ADDR_W-1:0] stride_1_i,
  input  logic [ADDR_W-1:0] stride_2_i,
  input  logic [ADDR_W-1:0] stride_3_i,
  input  logic [ADDR_W-1:0] base_i,
  loop_addr_gen_if.master   beat_if,
  output logic              busy_o,
  output logic              done_o
`ifdef LOOP_GEN_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] IDX_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  max_in    [4];
  logic [ADDR_W-1:0] stride_in [4];
  logic [CNT_W-1:0]  lim_in    [4];
  logic [CNT_W-1:0]  lim_q     [4];
  logic [CNT_W-1:0]  idx_q     [4];
  logic [CNT_W-1:0]  idx_step  [4];
  logic [ADDR_W-1:0] stride_q  [4];
  logic [ADDR_W-1:0] acc_q     [4];
  logic [ADDR_W-1:0] acc_step  [4];
  logic [3:0]        at_lim, step_at_lim, lim_in_zero, upd;
  logic              load, step;
  logic              valid_q, busy_q, done_q, last_q, last_d;
  logic              low_wrap;
  logic [ADDR_W-1:0] carry;

  assign max_in[0]    = max_0_i;
  assign max_in[1]    = max_1_i;
  assign max_in[2]    = max_2_i;
  assign max_in[3]    = max_3_i;
  assign stride_in[0] = stride_0_i;
  assign stride_in[1] = stride_1_i;
  assign stride_in[2] = stride_2_i;
  assign stride_in[3] = stride_3_i;

  // Bounds are stored as the final index value (M_k-1); a zero trip count behaves as one.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lvl
    assign lim_in[gi]      = (max_in[gi] == '0) ? '0 : max_in[gi] - IDX_ONE;
    assign lim_in_zero[gi] = (lim_in[gi] == '0);
    assign at_lim[gi]      = (idx_q[gi] == lim_q[gi]);
    assign step_at_lim[gi] = (idx_step[gi] == lim_q[gi]);
  end

  // Carry chain: a level updates when every level below it is at its bound. The carry
  // value descends from the lowest non-wrapping level, so each wrapped level below it
  // reloads the advancing level's freshly incremented accumulator.
  always_comb begin
    low_wrap = 1'b1;
    for (int k = 0; k < 4; k++) begin
      upd[k]   = low_wrap;
      low_wrap = low_wrap & at_lim[k];
    end
    carry = '0;
    for (int k = 3; k >= 0; k--) begin
      if (!at_lim[k]) carry = acc_q[k] + stride_q[k];
      acc_step[k] = upd[k] ? carry : acc_q[k];
      idx_step[k] = upd[k] ? (at_lim[k] ? '0 : idx_q[k] + IDX_ONE) : idx_q[k];
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) begin
        load    = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (beat_if.addr_ready) begin
          if (last_q) state_d = S_DONE;
          else        step    = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (load)      last_d = &lim_in_zero;
    else if (step) last_d = &step_at_lim;
    else           last_d = last_q & (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        lim_q[k]    <= '0;
        stride_q[k] <= '0;
        idx_q[k]    <= '0;
        acc_q[k]    <= '0;
      end
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == S_RUN);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      last_q  <= last_d;
      for (int k = 0; k < 4; k++) begin
        if (load) begin
          lim_q[k]    <= lim_in[k];
          stride_q[k] <= stride_in[k];
          idx_q[k]    <= '0;
          acc_q[k]    <= base_i;
        end else if (step) begin
          idx_q[k] <= idx_step[k];
          acc_q[k] <= acc_step[k];
        end
      end
    end
  end

`ifdef LOOP_GEN_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (load)
      stall_cnt_d = '0;
    else if (valid_q && !beat_if.addr_ready && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  assign beat_if.addr_valid = valid_q;
  assign beat_if.addr       = acc_q[0];
  assign beat_if.idx_0      = idx_q[0];
  assign beat_if.idx_1      = idx_q[1];
  assign beat_if.idx_2      = idx_q[2];
  assign beat_if.idx_3      = idx_q[3];
  assign beat_if.last       = last_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;

endmodule

// File: doc/loop_addr_gen.md
# loop_addr_gen

Single-clock, four-level nested-loop sequencer that walks a convolution/tiling iteration space and emits one linear memory address per beat over a valid/ready handshake. It sits directly downstream of the loop-count configuration and feeds the SRAM read port / systolic-array feeder. It replaces chained counters that use gated clocks with one fully synchronous carry chain. Address generation is incremental: no multipliers.

## Interface
Parameters:
- CNT_W, 32, width of loop bounds and indices.
- ADDR_W, 16, width of base, strides and address.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rstn  input  1  asynchronous, active-low reset.
- start  input  1  begin a run; sampled only in IDLE.
- abort  input  1  synchronous cancel; returns to IDLE with no done pulse.
- MAX_0..MAX_3  input  CNT_W each  trip count per level; level 0 is innermost. Captured on start.
- STRIDE_0..STRIDE_3  input  ADDR_W each  address increment per level. Captured on start.
- BASE  input  ADDR_W  start address. Captured on start.
- addr_valid  output  1  address beat valid.
- addr_ready  input  1  downstream accepts the beat.
- addr  output  ADDR_W  current address.
- idx_0..idx_3  output  CNT_W each  current loop indices.
- last  output  1  current beat is the final beat of the run.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse after the final beat is accepted.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1, capture config, clear indices, set addr=BASE, go to RUN.
  - RUN: addr_valid=1. The handshake (addr_valid & addr_ready) advances the iteration.
    - On the handshake of the beat with last=1, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Effective bound: M_k = (MAX_k==0) ? 1 : MAX_k. idx_k runs from 0 to M_k-1.
- Carry chain on advance:
  - Find the lowest level k with idx_k < M_k-1.
  - Set idx_k+1.
  - Set idx_j=0 for every j<k.
- Address accumulators acc_0..acc_3, where acc_k = BASE + Σ_{j≥k} idx_j·STRIDE_j.
  - On advance at level k: acc_k += STRIDE_k.
  - Every acc_j with j<k takes the new acc_k value.
  - addr = acc_0.
- Arithmetic is unsigned modulo 2^ADDR_W. Address wrap-around is silent.
- last = RUN & (idx_k == M_k-1 for all k).
- Total beats per run = M_0·M_1·M_2·M_3.
- Boundary conditions:
  - abort outside RUN is ignored.
  - abort has priority over the handshake in the same cycle. That beat is not counted as accepted, and the next state is IDLE.
  - start while busy is ignored.
  - Config inputs may change freely after start without effect on the run.
  - Reset mid-run returns to IDLE immediately (async). No done pulse is generated.

## Timing
- Reset values: state=IDLE; addr_valid, last, busy and done all 0; addr=0; idx_0..idx_3=0; stall counter 0.
- start seen in IDLE at edge N: addr_valid=1 and addr=BASE from cycle N+1.
- One beat per cycle is sustained while addr_ready=1 (zero bubbles).
- While addr_ready=0, addr, idx_* and last hold stable and addr_valid stays high. Withdrawing addr_valid without a handshake is forbidden.
- Final handshake at edge N: the FSM is in DONE during cycle N+1 (done=1, addr_valid=0) and in IDLE from cycle N+2.
- A new start may be issued in cycle N+2.
- All outputs are registered. There is no combinational path from addr_ready to any output.

## Configuration
- LOOP_GEN_STALL_CNT_EN defined:
  - Adds output stall_cnt (output, 32 bits).
  - Counts cycles with addr_valid & ~addr_ready; saturates at 2^32-1.
  - Clears on start accepted and on reset. Holds its value after done.
- LOOP_GEN_STALL_CNT_EN undefined: port and counter absent. All other behaviour identical.

## Test plan
- Basic run: MAX=2,3,1,1, STRIDE=1,2,0,0, BASE=0x10, ready=1 → addr sequence 0x10,0x11,0x12,0x13,0x14,0x15 on consecutive cycles; last on the 6th beat; done one cycle later; busy low the cycle after that.
- Backpressure: same config, ready toggled 1,0,0,1,… → no beat duplicated or skipped, and addr/idx stable while stalled. With LOOP_GEN_STALL_CNT_EN, stall_cnt equals the number of ready=0 cycles with valid high.
- Zero bound and wrap: MAX=0,0,0,4, STRIDE_3=0x8000, BASE=0xC000 → 4 beats: 0xC000, 0x4000, 0xC000, 0x4000. MAX=0 levels behave as 1.
- Large nest: MAX=16,4,392,3, random ready → 75264 beats; final idx=15,3,391,2; addr matches the reference model Σ idx·stride mod 2^16.
- Abort: abort asserted on beat 5 together with ready=1 → next cycle IDLE, done never pulses, and a new start restarts at BASE.
- Reset mid-run: rstn low mid-run → all outputs at reset values immediately. After release, start behaves normally.
